// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative radix-2 shift-add multiply / restoring divide producing HI/LO.
// One bit per cycle over WIDTH RUN cycles, then a sign-fix cycle, then a one-cycle done pulse.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic               sa, sb, ge;
    logic [WIDTH-1:0]   mag_a, mag_b, rem_next;
    logic [WIDTH:0]     sum, trial;
    logic [2*WIDTH-1:0] prod_neg;

    // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
    always_comb begin
        sa       = op_signed & opa[WIDTH-1];
        sb       = op_signed & opb[WIDTH-1];
        mag_a    = sa ? -opa : opa;
        mag_b    = sb ? -opb : opb;
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        ge       = trial >= {1'b0, m_q};
        rem_next = ge ? trial[WIDTH-1:0] - m_q : trial[WIDTH-1:0];
        prod_neg = -acc_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        m_d      = m_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    div_d    = op_div;
                    neg_lo_d = sa ^ sb;
                    neg_hi_d = op_div ? sa : sa ^ sb;
                    cnt_d    = CNTW'(WIDTH - 1);
                    dz_d     = 1'b0;
                    if (op_div && opb == '0) begin
                        state_d = DONE;
                        dz_d    = 1'b1;
                        hi_d    = opa;
                        lo_d    = '1;
                    end else begin
                        state_d = RUN;
                        m_d     = op_div ? mag_b : mag_a;
                        acc_d   = {{WIDTH{1'b0}}, op_div ? mag_a : mag_b};
                    end
                end
            end
            RUN: begin
                acc_d   = div_q ? {rem_next, acc_q[WIDTH-2:0], ge} : {sum, acc_q[WIDTH-1:1]};
                cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                state_d = cnt_q == '0 ? FIX : RUN;
            end
            FIX: begin
                state_d = DONE;
                if (div_q) begin
                    hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? prod_neg : acc_q;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            m_q      <= m_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
        end
    end

    assign busy     = state_q == RUN || state_q == FIX;
    assign done     = state_q == DONE;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed-vector bench for muldiv_sequencer with hand-computed results.
module tb_muldiv_sequencer;
    localparam int W = 32;

    typedef struct packed {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    logic         clock = 1'b0, reset = 1'b0, start = 1'b0, op_div = 1'b0, op_signed = 1'b0;
    logic [W-1:0] opa = '0, opb = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
    int           errors = 0, checks = 0;

    vec_t mul_vec[5] = '{
        '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
        '{1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB},
        '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780},
        '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
        '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001}
    };

    vec_t div_vec[8] = '{
        '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
        '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
        '{1'b0, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E},
        '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
        '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF},
        '{1'b0, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC},
        '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003},
        '{1'b0, 32'h00000005, 32'h00000009, 32'h00000005, 32'h00000000}
    };

    muldiv_sequencer #(.WIDTH(W), .CNTW(6)) dut (
        .clock(clock), .reset(reset), .start(start), .op_div(op_div), .op_signed(op_signed),
        .opa(opa), .opb(opb), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    // Drives start for exactly one edge; returns at the negedge of cycle 1 with operands scrambled.
    task automatic issue(input logic d, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        start = 1'b1; op_div = d; op_signed = s; opa = a; opb = b;
        @(negedge clock);
        start = 1'b0; opa = $urandom; opb = $urandom; op_signed = ~s;
    endtask

    task automatic run_op(input logic d, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int cyc, output int bcyc);
        issue(d, s, a, b);
        cyc = 1; bcyc = 0;
        while (!done && cyc < 100) begin
            if (busy) bcyc++;
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", div_zero); end
        checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        reset = 1'b1;
    endtask

    task automatic test_table(input logic d, input vec_t v, input int idx);
        int cyc, bcyc;
        run_op(d, v.s, v.a, v.b, cyc, bcyc);
        checks++; if (cyc !== W + 2) begin errors++; $display("FAIL latency div=%0b #%0d: got %0d expected %0d", d, idx, cyc, W + 2); end
        checks++; if (bcyc !== W + 1) begin errors++; $display("FAIL busy_len div=%0b #%0d: got %0d expected %0d", d, idx, bcyc, W + 1); end
        checks++; if (hi !== v.hi) begin errors++; $display("FAIL hi div=%0b #%0d: got %h expected %h", d, idx, hi, v.hi); end
        checks++; if (lo !== v.lo) begin errors++; $display("FAIL lo div=%0b #%0d: got %h expected %h", d, idx, lo, v.lo); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz div=%0b #%0d: got %b expected 0", d, idx, div_zero); end
        @(negedge clock);
        checks++; if (done !== 1'b0 || hi !== v.hi || lo !== v.lo) begin
            errors++; $display("FAIL pulse_hold div=%0b #%0d: got done=%b hi=%h lo=%h expected done=0 hi=%h lo=%h", d, idx, done, hi, lo, v.hi, v.lo);
        end
    endtask

    task automatic test_mul();
        for (int i = 0; i < 5; i++) test_table(1'b0, mul_vec[i], i);
    endtask

    task automatic test_div();
        for (int i = 0; i < 8; i++) test_table(1'b1, div_vec[i], i);
    endtask

    task automatic test_div_zero();
        int cyc, bcyc;
        run_op(1'b1, 1'b1, 32'h00001234, 32'h0, cyc, bcyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", cyc); end
        checks++; if (bcyc !== 0) begin errors++; $display("FAIL dz_busy: got %0d expected 0", bcyc); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_lo: got %h expected ffffffff", lo); end
        checks++; if (hi !== 32'h00001234) begin errors++; $display("FAIL dz_hi: got %h expected 00001234", hi); end
        checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", div_zero); end
        repeat (4) @(negedge clock);
        checks++; if (div_zero !== 1'b1 || hi !== 32'h00001234) begin
            errors++; $display("FAIL dz_hold: got dz=%b hi=%h expected dz=1 hi=00001234", div_zero, hi);
        end
        run_op(1'b0, 1'b0, 32'd2, 32'd3, cyc, bcyc);
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b expected 0", div_zero); end
        checks++; if (lo !== 32'd6 || hi !== 32'd0) begin errors++; $display("FAIL dz_next: got hi=%h lo=%h expected hi=0 lo=6", hi, lo); end
    endtask

    task automatic test_ignore_start();
        int cyc, bcyc, extra;
        issue(1'b0, 1'b0, 32'd6, 32'd7);
        cyc = 1;
        while (!done && cyc < 100) begin
            if (cyc == 5) begin start = 1'b1; op_div = 1'b1; opa = 32'd100; opb = 32'd3; end
            else start = 1'b0;
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        checks++; if (cyc !== W + 2) begin errors++; $display("FAIL ign_latency: got %0d expected %0d", cyc, W + 2); end
        checks++; if (lo !== 32'd42 || hi !== 32'd0) begin errors++; $display("FAIL ign_result: got hi=%h lo=%h expected hi=0 lo=2a", hi, lo); end
        start = 1'b1; op_div = 1'b1; opa = 32'd100; opb = 32'd3;
        @(negedge clock);
        start = 1'b0;
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ign_no_queue: got %0d active cycles expected 0", extra); end
        run_op(1'b1, 1'b0, 32'd100, 32'd3, cyc, bcyc);
        checks++; if (lo !== 32'd33 || hi !== 32'd1 || cyc !== W + 2) begin
            errors++; $display("FAIL ign_reissue: got hi=%h lo=%h cyc=%0d expected hi=1 lo=21 cyc=%0d", hi, lo, cyc, W + 2);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bcyc, extra;
        issue(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL mid_data: got hi=%h lo=%h expected 0 0", hi, lo); end
        reset = 1'b1;
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL mid_no_done: got %0d active cycles expected 0", extra); end
        run_op(1'b0, 1'b1, 32'hFFFFFFFD, 32'd7, cyc, bcyc);
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB || cyc !== W + 2) begin
            errors++; $display("FAIL mid_after: got hi=%h lo=%h cyc=%0d expected hi=ffffffff lo=ffffffeb cyc=%0d", hi, lo, cyc, W + 2);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
